// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus types: arbiter FSM states and the bus-operation encoding also used by the Cpu.
// The arbiter's starvation counters are built only when CPU_BUS_FAIRNESS_EN is defined.
package cpu_bus_pkg;

  typedef enum logic [0:0] {
    BUS_IDLE   = 1'b0,
    BUS_ACCESS = 1'b1
  } bus_state_t;

  // Bus operation encoding as {read, write}.
  localparam logic [1:0] IO_NONE  = 2'b00;
  localparam logic [1:0] IO_READ  = 2'b10;
  localparam logic [1:0] IO_WRITE = 2'b01;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;

  function automatic logic [1:0] io_kind(input logic we);
    return we ? IO_WRITE : IO_READ;
  endfunction

endpackage

// File: rtl/cpu_bus_arb_pick.sv
// Combinational winner selection: starved requesters first, then lowest index.
module cpu_bus_arb_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] starved_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  logic [NUM_REQ-1:0] pool;

  always_comb begin
    pool     = ((req_i & starved_i) != '0) ? (req_i & starved_i) : req_i;
    valid_o  = (req_i != '0);
    idx_o    = '0;
    onehot_o = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pool[i]) begin
        idx_o       = IDX_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the CPU memory bus between fetch/operand/stack requesters; one access in flight at a time.
// Define CPU_BUS_FAIRNESS_EN to add per-requester starvation counters (forced grant at STARVE_LIMIT).
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int WAIT_STATES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*16-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [15:0]            mem_address,
  output logic [7:0]             mem_dataOut,
  input  logic [7:0]             mem_dataIn
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  bus_state_t            state_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [NUM_REQ-1:0]    owner_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  busy_q;
  logic [1:0]            io_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic [NUM_REQ-1:0]    starved;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic                  arb_go;

  cpu_bus_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i     (req),
    .starved_i (starved),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx),
    .onehot_o  (pick_onehot)
  );

  assign arb_go = (state_q == BUS_IDLE) && pick_valid;

`ifdef CPU_BUS_FAIRNESS_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQ-1:0][CNT_W-1:0] starve_q;
  logic [NUM_REQ-1:0][CNT_W-1:0] starve_d;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = (32'(starve_q[i]) >= 32'(STARVE_LIMIT));
    end
  end

  // Losers that were requesting age by one (saturating); the winner restarts from zero.
  always_comb begin
    starve_d = starve_q;
    if (arb_go) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick_onehot[i]) begin
          starve_d[i] = '0;
        end else if (req[i] && (32'(starve_q[i]) < 32'(STARVE_LIMIT))) begin
          starve_d[i] = starve_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_limit;

  assign starved      = '0;
  assign unused_limit = (STARVE_LIMIT > 0);
`endif

  // Every output comes straight from a register; busy doubles as the visible FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      wait_q  <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      io_q    <= IO_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        BUS_IDLE: begin
          if (arb_go) begin
            state_q <= BUS_ACCESS;
            wait_q  <= WAIT_W'(WAIT_STATES);
            owner_q <= pick_onehot;
            gnt_q   <= pick_onehot;
            busy_q  <= 1'b1;
            io_q    <= io_kind(req_we[pick_idx]);
            addr_q  <= req_addr[16*pick_idx +: 16];
            wdata_q <= req_wdata[8*pick_idx +: 8];
          end else begin
            busy_q  <= 1'b0;
            io_q    <= IO_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
          end
        end
        BUS_ACCESS: begin
          if (wait_q == '0) begin
            state_q <= BUS_IDLE;
            done_q  <= owner_q;
            if (io_q == IO_READ) begin
              rdata_q <= mem_dataIn;
            end
            busy_q  <= 1'b0;
            io_q    <= IO_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        default: begin
          state_q <= BUS_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign mem_read    = io_q[1];
  assign mem_write   = io_q[0];
  assign mem_address = addr_q;
  assign mem_dataOut = wdata_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: two instances (WAIT_STATES 0 and 2), timeline-based reference model.
module tb_cpu_bus_arbiter;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic [2:0]  req         [2];
  logic [2:0]  req_we      [2];
  logic [47:0] req_addr    [2];
  logic [23:0] req_wdata   [2];
  logic [2:0]  gnt         [2];
  logic [2:0]  done        [2];
  logic [7:0]  rdata       [2];
  logic        busy        [2];
  logic        mem_read    [2];
  logic        mem_write   [2];
  logic [15:0] mem_address [2];
  logic [7:0]  mem_dataOut [2];
  logic [7:0]  mem_dataIn  [2];
  logic [7:0]  dev_mem     [2][256];

  cpu_bus_arbiter #(.NUM_REQ(3), .WAIT_STATES(0), .STARVE_LIMIT(STARVE)) u_ws0 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .gnt(gnt[0]), .done(done[0]), .rdata(rdata[0]), .busy(busy[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
    .mem_dataOut(mem_dataOut[0]), .mem_dataIn(mem_dataIn[0])
  );

  cpu_bus_arbiter #(.NUM_REQ(3), .WAIT_STATES(2), .STARVE_LIMIT(STARVE)) u_ws2 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .gnt(gnt[1]), .done(done[1]), .rdata(rdata[1]), .busy(busy[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
    .mem_dataOut(mem_dataOut[1]), .mem_dataIn(mem_dataIn[1])
  );

  // Bus devices: asynchronous read, write on the clock edge while the strobe is high.
  always_comb begin
    for (int u = 0; u < 2; u++) mem_dataIn[u] = dev_mem[u][mem_address[u][7:0]];
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_write[u]) dev_mem[u][mem_address[u][7:0]] <= mem_dataOut[u];
    end
  end

  // Reference model state: one access record per unit, placed on a cycle timeline.
  int          cyc;
  int          checks;
  int          failures;
  bit          act_v     [2];
  int          act_s     [2];
  int          act_i     [2];
  bit          act_we    [2];
  logic [15:0] act_a     [2];
  logic [7:0]  act_d     [2];
  int          next_arb  [2];
  int          cnt       [2][3];
  logic [7:0]  mdl_mem   [2][256];
  logic [7:0]  rdata_exp [2];
  logic [7:0]  exp_q     [2][$];
  logic [2:0]  drop_mask [2];

  function automatic int ws(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s u%0d cyc=%0d observed=%0h expected=%0h", tag, u, cyc, obs, exp);
    end
  endtask

  // Decide what the arbiter does with the inputs present during the current cycle.
  task automatic model_cycle(input int u);
    logic [2:0] starved;
    logic [2:0] pool;
    int w;
    if (rst[u]) begin
      act_v[u] = 1'b0;
      exp_q[u].delete();
      rdata_exp[u] = 8'h00;
      for (int i = 0; i < 3; i++) cnt[u][i] = 0;
      next_arb[u] = cyc + 1;
      return;
    end
    if (cyc < next_arb[u] || req[u] == 3'b000) return;
    starved = 3'b000;
`ifdef CPU_BUS_FAIRNESS_EN
    for (int i = 0; i < 3; i++) if (req[u][i] && cnt[u][i] >= STARVE) starved[i] = 1'b1;
`endif
    pool = (starved != 3'b000) ? starved : req[u];
    w = 0;
    for (int i = 2; i >= 0; i--) if (pool[i]) w = i;
`ifdef CPU_BUS_FAIRNESS_EN
    for (int i = 0; i < 3; i++) begin
      if (i == w) cnt[u][i] = 0;
      else if (req[u][i] && cnt[u][i] < STARVE) cnt[u][i]++;
    end
`endif
    act_v[u]  = 1'b1;
    act_s[u]  = cyc + 1;
    act_i[u]  = w;
    act_we[u] = req_we[u][w];
    act_a[u]  = req_addr[u][16*w +: 16];
    act_d[u]  = req_wdata[u][8*w +: 8];
    if (act_we[u]) mdl_mem[u][act_a[u][7:0]] = act_d[u];
    else exp_q[u].push_back(mdl_mem[u][act_a[u][7:0]]);
    next_arb[u] = cyc + 2 + ws(u);
  endtask

  task automatic check_unit(input int u);
    logic [2:0] g_e;
    logic [2:0] d_e;
    bit acc;
    g_e = 3'b000;
    d_e = 3'b000;
    acc = 1'b0;
    if (act_v[u]) begin
      if (cyc == act_s[u]) g_e = 3'(1 << act_i[u]);
      acc = (cyc >= act_s[u]) && (cyc <= act_s[u] + ws(u));
      if (cyc == act_s[u] + ws(u) + 1) begin
        d_e = 3'(1 << act_i[u]);
        if (!act_we[u] && exp_q[u].size() > 0) rdata_exp[u] = exp_q[u].pop_front();
      end
    end
    chk("gnt", u, 32'(gnt[u]), 32'(g_e));
    chk("done", u, 32'(done[u]), 32'(d_e));
    chk("busy", u, 32'(busy[u]), 32'(acc));
    chk("mem_read", u, 32'(mem_read[u]), 32'(acc && !act_we[u]));
    chk("mem_write", u, 32'(mem_write[u]), 32'(acc && act_we[u]));
    chk("mem_address", u, 32'(mem_address[u]), acc ? 32'(act_a[u]) : 32'h0);
    if (acc && act_we[u]) chk("mem_dataOut", u, 32'(mem_dataOut[u]), 32'(act_d[u]));
    chk("rdata", u, 32'(rdata[u]), 32'(rdata_exp[u]));
  endtask

  task automatic step();
    for (int u = 0; u < 2; u++) model_cycle(u);
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      check_unit(u);
      req[u] = req[u] & ~(gnt[u] & drop_mask[u]);
    end
  endtask

  task automatic rand_drive(input int u);
    for (int i = 0; i < 3; i++) begin
      if (!req[u][i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req[u][i]              = 1'b1;
          req_we[u][i]           = 1'($urandom_range(0, 1));
          req_addr[u][16*i +: 16] = 16'($urandom);
          req_wdata[u][8*i +: 8]  = 8'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        req[u][i] = 1'b0;
      end
    end
  endtask

  int order_q[$];
  int wcount, first_w, last_w, done_cyc, dcount, arb_n, win_at, d1, g2, gcount, gap;
  bit seen_strobe, in_gap;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      req[u] = 3'b000;
      req_we[u] = 3'b000;
      req_addr[u] = '0;
      req_wdata[u] = '0;
      drop_mask[u] = 3'b111;
      act_v[u] = 1'b0;
      rdata_exp[u] = 8'h00;
      next_arb[u] = 0;
      for (int i = 0; i < 3; i++) cnt[u][i] = 0;
      for (int a = 0; a < 256; a++) begin
        dev_mem[u][a] = 8'($urandom);
        mdl_mem[u][a] = dev_mem[u][a];
      end
    end

    // Reset: every cycle checks all outputs at zero.
    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();

    // Single uncontended read, zero wait states.
    dev_mem[0][3] = 8'hE8;
    mdl_mem[0][3] = 8'hE8;
    req_we[0] = 3'b000;
    req_addr[0][15:0] = 16'h0003;
    req[0] = 3'b001;
    step();
    chk("t1_gnt", 0, 32'(gnt[0]), 32'h1);
    chk("t1_mem_read", 0, 32'(mem_read[0]), 32'h1);
    chk("t1_addr", 0, 32'(mem_address[0]), 32'h0003);
    step();
    chk("t1_done", 0, 32'(done[0]), 32'h1);
    chk("t1_rdata", 0, 32'(rdata[0]), 32'hE8);

    // Three simultaneous readers, each drops its request once granted.
    req_addr[0] = {16'h0012, 16'h0011, 16'h0010};
    req_we[0] = 3'b000;
    req[0] = 3'b111;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2_onehot", 0, 32'($countones(gnt[0]) <= 1), 32'h1);
      for (int i = 0; i < 3; i++) if (gnt[0][i]) order_q.push_back(i);
    end
    chk("t2_grants", 0, 32'(order_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t2_order", 0, (order_q.size() > i) ? 32'(order_q[i]) : 32'hFFFF, 32'(i));

    // Write with two wait states on the second instance.
    req_we[1] = 3'b100;
    req_addr[1][47:32] = 16'h8001;
    req_wdata[1][23:16] = 8'h5A;
    req[1] = 3'b100;
    wcount = 0; first_w = -1; last_w = -1; done_cyc = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (mem_write[1]) begin
        wcount++;
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
      end
      if (done[1] == 3'b100) done_cyc = cyc;
    end
    chk("t3_write_cycles", 1, 32'(wcount), 32'd3);
    chk("t3_done_after", 1, 32'(done_cyc - last_w), 32'd1);
    chk("t3_dev_mem", 1, 32'(dev_mem[1][8'h01]), 32'h5A);

    // Reset during the second access cycle of a read: abort with no completion.
    req_we[1] = 3'b000;
    req_addr[1][15:0] = 16'h0040;
    req[1] = 3'b001;
    for (int k = 0; k < 4 && busy[1] !== 1'b1; k++) step();
    chk("t4_started", 1, 32'(busy[1]), 32'h1);
    step();
    chk("t4_second_cycle", 1, 32'(mem_read[1]), 32'h1);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    chk("t4_read_low", 1, 32'(mem_read[1]), 32'h0);
    chk("t4_write_low", 1, 32'(mem_write[1]), 32'h0);
    chk("t4_busy_low", 1, 32'(busy[1]), 32'h0);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done[1] != 3'b000) dcount++;
    end
    chk("t4_no_done", 1, 32'(dcount), 32'd0);

    // Index 0 held permanently against index 2.
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    drop_mask[0] = 3'b100;
    req_we[0] = 3'b000;
    req[0] = 3'b101;
    arb_n = 0;
    win_at = 0;
    for (int k = 0; k < 60 && arb_n < 20 && win_at == 0; k++) begin
      step();
      if (gnt[0] != 3'b000) arb_n++;
      if (gnt[0][2]) win_at = arb_n;
    end
`ifdef CPU_BUS_FAIRNESS_EN
    chk("t5_starved_win", 0, 32'(win_at), 32'd5);
`else
    chk("t5_never_won", 0, 32'(win_at), 32'd0);
    chk("t5_rounds", 0, 32'(arb_n), 32'd20);
`endif
    req[0] = 3'b000;
    drop_mask[0] = 3'b111;
    repeat (4) step();

    // Back-to-back reads from index 1: re-arbitration in the done cycle.
    drop_mask[0] = 3'b000;
    req_we[0] = 3'b000;
    req_addr[0][31:16] = 16'h0021;
    req[0] = 3'b010;
    d1 = -1; g2 = -1; gcount = 0; gap = 0;
    seen_strobe = 1'b0; in_gap = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (gnt[0][1]) begin
        gcount++;
        if (gcount == 2) begin
          g2 = cyc;
          req[0] = 3'b000;
        end
      end
      if (done[0][1] && d1 < 0) d1 = cyc;
      if (mem_read[0]) begin
        if (in_gap) in_gap = 1'b0;
        seen_strobe = 1'b1;
      end else if (seen_strobe && g2 < 0) begin
        in_gap = 1'b1;
        gap++;
      end
    end
    chk("t6_two_grants", 0, 32'(gcount), 32'd2);
    chk("t6_rearb", 0, 32'(g2 - d1), 32'd1);
    chk("t6_gap", 0, 32'(gap), 32'd1);
    drop_mask[0] = 3'b111;
    repeat (3) step();

    // Random traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      rand_drive(0);
      rand_drive(1);
      step();
    end
    req[0] = 3'b000;
    req[1] = 3'b000;
    repeat (12) step();
    chk("drain_q0", 0, 32'(exp_q[0].size()), 32'd0);
    chk("drain_q1", 1, 32'(exp_q[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
